// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-access stage SRAM controller.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int SRAM_ADDR_W_DEF = 18;
    localparam int WAIT_CYCLES_DEF = 2;

    // Halfword select appended as the SRAM address LSB.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_access_ctrl.sv
// Sequences 32-bit loads/stores as two 16-bit accesses to an asynchronous
// SRAM, freezing the pipeline (ready = 0) while an access is in flight.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   ready,
    output logic [31:0]            read_data,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        last;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        unused_addr_bits;

    // Only addr[18:2] selects the word; the rest is deliberately ignored.
    assign unused_addr_bits = ^{addr[31:19], addr[1:0]};

    // Final cycle of a half-access phase.
    assign last = (cnt == CNT_LAST);

    // State and wait-counter registers; reset abandons any access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the request operands on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && (mem_r_en || mem_w_en)) begin
            word_q  <= addr[18:2];
            wdata_q <= wdata;
        end
    end

    // Assemble the load word from the two SRAM halves; held between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= 32'd0;
        end else if (last) begin
            if (state == RD_LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == RD_HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Next-state, counter and ready decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (mem_w_en) begin
                    state_nxt = WR_LO;
                end else if (mem_r_en) begin
                    state_nxt = RD_LO;
                end else begin
                    ready = 1'b1;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                if (last) begin
                    cnt_nxt = 4'd0;
                    case (state)
                        RD_LO:   state_nxt = RD_HI;
                        WR_LO:   state_nxt = WR_HI;
                        default: state_nxt = DONE;
                    endcase
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                // A request still visible here belongs to the access just completed.
                ready     = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // SRAM pins decoded from registers only; strobe rises on each phase's last cycle.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        case (state)
            RD_LO: sram_addr = SRAM_ADDR_W'({word_q, HALF_LO});
            RD_HI: sram_addr = SRAM_ADDR_W'({word_q, HALF_HI});
            WR_LO: begin
                sram_addr   = SRAM_ADDR_W'({word_q, HALF_LO});
                sram_we_n   = (cnt >= CNT_LAST);
                sram_dq_out = wdata_q[15:0];
                sram_dq_oe  = 1'b1;
            end
            WR_HI: begin
                sram_addr   = SRAM_ADDR_W'({word_q, HALF_HI});
                sram_we_n   = (cnt >= CNT_LAST);
                sram_dq_out = wdata_q[31:16];
                sram_dq_oe  = 1'b1;
            end
            default: begin
                sram_addr   = '0;
                sram_we_n   = 1'b1;
                sram_dq_out = 16'd0;
                sram_dq_oe  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: halfword SRAM models behind two instances
// (WAIT_CYCLES 2 and 4) and a word-level reference memory.
module tb_mem_access_ctrl;

    localparam int WC  = 2;
    localparam int WC4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A (WAIT_CYCLES = 2)
    logic        r_en, w_en;
    logic [31:0] addr, wdata, read_data;
    logic        ready, we_n, dq_oe;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;

    // Instance B (WAIT_CYCLES = 4)
    logic        b_r_en, b_w_en;
    logic [31:0] b_addr, b_wdata, b_read_data;
    logic        b_ready, b_we_n, b_dq_oe;
    logic [17:0] b_sram_addr;
    logic [15:0] b_dq_out, b_dq_in;

    mem_access_ctrl #(.WAIT_CYCLES(WC), .SRAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
        .addr(addr), .wdata(wdata), .ready(ready), .read_data(read_data),
        .sram_addr(sram_addr), .sram_we_n(we_n), .sram_dq_out(dq_out),
        .sram_dq_oe(dq_oe), .sram_dq_in(dq_in)
    );

    mem_access_ctrl #(.WAIT_CYCLES(WC4), .SRAM_ADDR_W(18)) dut4 (
        .clk(clk), .rst(rst), .mem_r_en(b_r_en), .mem_w_en(b_w_en),
        .addr(b_addr), .wdata(b_wdata), .ready(b_ready), .read_data(b_read_data),
        .sram_addr(b_sram_addr), .sram_we_n(b_we_n), .sram_dq_out(b_dq_out),
        .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in)
    );

    // Asynchronous SRAM models: read is combinational, write lands on the strobe's rising edge.
    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];
    assign dq_in   = mem_a[sram_addr[9:0]];
    assign b_dq_in = mem_b[b_sram_addr[9:0]];

    always @(posedge we_n) begin
        if (rst === 1'b1 && dq_oe === 1'b1) mem_a[sram_addr[9:0]] <= dq_out;
    end
    always @(posedge b_we_n) begin
        if (rst === 1'b1 && b_dq_oe === 1'b1) mem_b[b_sram_addr[9:0]] <= b_dq_out;
    end

    // Word-level reference for instance A
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rd;

    int tests = 0;
    int fails = 0;

    // Observations gathered while an access on instance A runs
    logic [17:0] qa_addr[$];
    logic [15:0] qa_data[$];
    int          qa_oe;

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Random byte address inside the modelled range, word bit 8 clear.
    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[18:10] = 9'd0;
        return a;
    endfunction

    task automatic idle_a();
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        qa_addr.delete(); qa_data.delete(); qa_oe = 0;
        lat = 0;
        @(posedge clk); #1;
        r_en = r; w_en = w; addr = a; wdata = d;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (we_n === 1'b0) begin
                qa_addr.push_back(sram_addr);
                qa_data.push_back(dq_out);
            end
            if (dq_oe === 1'b1) qa_oe++;
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
            addr = $urandom; wdata = $urandom;
        end
    endtask

    task automatic store_a(input logic [31:0] a, input logic [31:0] d, input bit both, input string tag);
        int lat;
        logic [31:0] rd_before;
        logic [17:0] ea;
        logic [15:0] ed;
        rd_before = read_data;
        drive_a(both, 1'b1, a, d, lat);
        tests++;
        if (lat !== 2*WC+2) begin
            fails++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, 2*WC+2);
        end
        tests++;
        if (qa_addr.size() != 2*(WC-1)) begin
            fails++; $display("FAIL %s strobe_cycles: got %0d expected %0d", tag, qa_addr.size(), 2*(WC-1));
        end
        for (int i = 0; i < qa_addr.size() && i < 2*(WC-1); i++) begin
            ea = {a[18:2], 1'(i >= WC-1)};
            ed = (i >= WC-1) ? d[31:16] : d[15:0];
            tests++;
            if (qa_addr[i] !== ea || qa_data[i] !== ed) begin
                fails++;
                $display("FAIL %s strobe[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         tag, i, qa_addr[i], qa_data[i], ea, ed);
            end
        end
        tests++;
        if (qa_oe != 2*WC) begin
            fails++; $display("FAIL %s oe_cycles: got %0d expected %0d", tag, qa_oe, 2*WC);
        end
        if (both) begin
            tests++;
            if (read_data !== rd_before) begin
                fails++; $display("FAIL %s read_data_kept: got %h expected %h", tag, read_data, rd_before);
            end
        end
        ref_mem[a[9:2]] = d;
    endtask

    task automatic load_a(input logic [31:0] a, input string tag);
        int lat;
        drive_a(1'b1, 1'b0, a, $urandom, lat);
        exp_rd = ref_mem[a[9:2]];
        tests++;
        if (lat !== 2*WC+2) begin
            fails++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, 2*WC+2);
        end
        tests++;
        if (read_data !== exp_rd) begin
            fails++; $display("FAIL %s read_data: got %h expected %h", tag, read_data, exp_rd);
        end
        tests++;
        if (qa_addr.size() != 0 || qa_oe != 0) begin
            fails++; $display("FAIL %s no_write: got strobes=%0d oe=%0d expected 0 0", tag, qa_addr.size(), qa_oe);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        r_en = 1'b1; w_en = 1'b0; addr = 32'h0000_0408; wdata = 32'h0;
        b_r_en = 1'b0; b_w_en = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 1'b0 || we_n !== 1'b1 || dq_oe !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got ready=%b we_n=%b oe=%b expected 0 1 0", ready, we_n, dq_oe);
        end
        tests++;
        if (read_data !== 32'd0 || sram_addr !== 18'd0 || dq_out !== 16'd0) begin
            fails++; $display("FAIL reset_data: got rd=%h addr=%h dq=%h expected 0 0 0", read_data, sram_addr, dq_out);
        end
        r_en = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready_idle: got %b expected 1", ready);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_rd = 32'd0;
    endtask

    task automatic test_store_fixed();
        store_a(32'h0000_0408, 32'hDEAD_BEEF, 1'b0, "store_fixed");
        idle_a();
    endtask

    task automatic test_load_fixed();
        load_a(32'h0000_0408, "load_fixed");
        idle_a();
    endtask

    task automatic test_both_requests();
        store_a(rnd_addr(), $urandom, 1'b1, "both_req");
        idle_a();
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) store_a(rnd_addr(), $urandom, 1'b0, "rand_store");
            else if (op == 1) load_a(rnd_addr(), "rand_load");
            else store_a(rnd_addr(), $urandom, 1'b1, "rand_both");
            if ($urandom_range(0, 1) == 1) idle_a();
        end
        idle_a();
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] a;
        a = rnd_addr();
        a[10] = 1'b1;
        @(posedge clk); #1;
        w_en = 1'b1; r_en = 1'b0; addr = a; wdata = $urandom;
        repeat (WC+2) @(negedge clk);
        tests++;
        if (we_n !== 1'b0 || sram_addr !== {a[18:2], 1'b1}) begin
            fails++; $display("FAIL midrst_in_wr_hi: got we_n=%b addr=%h expected 0 %h", we_n, sram_addr, {a[18:2], 1'b1});
        end
        rst = 1'b0;
        #1;
        tests++;
        if (we_n !== 1'b1 || dq_oe !== 1'b0 || sram_addr !== 18'd0 || dq_out !== 16'd0) begin
            fails++; $display("FAIL midrst_idle_pins: got we_n=%b oe=%b addr=%h dq=%h expected 1 0 0 0",
                              we_n, dq_oe, sram_addr, dq_out);
        end
        tests++;
        if (ready !== 1'b0 || read_data !== 32'd0) begin
            fails++; $display("FAIL midrst_state: got ready=%b rd=%h expected 0 0", ready, read_data);
        end
        w_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_rd = 32'd0;
        repeat (2) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || we_n !== 1'b1 || sram_addr !== 18'd0) begin
            fails++; $display("FAIL midrst_release: got ready=%b we_n=%b addr=%h expected 1 1 0", ready, we_n, sram_addr);
        end
        load_a(32'h0000_0408, "post_reset_load");
        idle_a();
    endtask

    task automatic test_back_to_back();
        int r1, r2;
        bit gap_ok;
        logic [31:0] rd_at_r1, ab, as, ds, exp_ld;
        logic [9:0]  w;
        r1 = 0; r2 = 0; gap_ok = 1'b0; rd_at_r1 = 32'h0;
        ab = rnd_addr(); as = rnd_addr(); ds = $urandom;
        w = {ab[10:2], 1'b0};
        exp_ld = {pat(int'(w) + 1), pat(int'(w))};
        @(posedge clk); #1;
        b_r_en = 1'b1; b_w_en = 1'b0; b_addr = ab; b_wdata = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (r1 != 0 && k == r1 + 1)
                gap_ok = (b_sram_addr === 18'd0 && b_dq_oe === 1'b0 && b_we_n === 1'b1 && b_ready === 1'b0);
            if (b_ready === 1'b1) begin
                if (r1 == 0) begin
                    r1 = k; rd_at_r1 = b_read_data;
                end else begin
                    r2 = k;
                    break;
                end
            end
            @(posedge clk); #1;
            if (k == r1) begin
                b_r_en = 1'b0; b_w_en = 1'b1; b_addr = as; b_wdata = ds;
            end
        end
        @(posedge clk); #1;
        b_r_en = 1'b0; b_w_en = 1'b0;
        tests++;
        if (r1 != 2*WC4+2) begin
            fails++; $display("FAIL b2b_load_ready: got cycle %0d expected %0d", r1, 2*WC4+2);
        end
        tests++;
        if (r2 != 4*WC4+4) begin
            fails++; $display("FAIL b2b_store_ready: got cycle %0d expected %0d", r2, 4*WC4+4);
        end
        tests++;
        if (!gap_ok) begin
            fails++; $display("FAIL b2b_idle_gap: got gap_ok=%b expected 1", gap_ok);
        end
        tests++;
        if (rd_at_r1 !== exp_ld) begin
            fails++; $display("FAIL b2b_load_data: got %h expected %h", rd_at_r1, exp_ld);
        end
        tests++;
        if ({mem_b[{as[10:2], 1'b1}], mem_b[{as[10:2], 1'b0}]} !== ds) begin
            fails++; $display("FAIL b2b_store_data: got %h expected %h",
                              {mem_b[{as[10:2], 1'b1}], mem_b[{as[10:2], 1'b0}]}, ds);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'd0;
            mem_b[i] = pat(i);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        exp_rd = 32'd0;
        test_reset();
        test_store_fixed();
        test_load_fixed();
        test_both_requests();
        test_random();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
